// File: rtl/score_event_tx.sv
`default_nettype none
// ============================================================================
// score_event_tx : accumulates hit credits and meters updateScore strobes
//                  into update-position windows, with saturation and flush.
// Revision 1.0
// ============================================================================
module score_event_tx #(
  parameter int PEND_W         = 5,
  parameter int MAX_PER_WINDOW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hit,
  input  logic [1:0]        hitPoints,
  input  logic              flush,
  input  logic              inUpdatePositionStateMain,
  output logic              updateScore,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              busy
);

  localparam int SUM_W = PEND_W + 2;
  localparam logic [SUM_W-1:0] c_pend_max = SUM_W'((1 << PEND_W) - 1);
  localparam logic [2:0]       c_win_max  = 3'(MAX_PER_WINDOW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] w_pending_nxt;
  logic [2:0]        r_win_cnt;
  logic [2:0]        w_win_cnt_nxt;
  logic              r_overflow;
  logic              w_overflow_nxt;
  logic              w_update;
  logic [SUM_W-1:0]  w_add;
  logic [SUM_W-1:0]  w_sum;
  logic              w_sat;

  // Non-IDLE state is equivalent to a nonzero pending count.
  assign w_update = (r_state != ST_IDLE) && inUpdatePositionStateMain &&
                    !flush && !reset && (r_win_cnt < c_win_max);

  always_comb begin
    w_add          = '0;
    w_sum          = '0;
    w_sat          = 1'b0;
    w_pending_nxt  = r_pending;
    w_win_cnt_nxt  = r_win_cnt;
    w_overflow_nxt = r_overflow;
    w_state_nxt    = r_state;

    if (hit) begin
      w_add = SUM_W'(hitPoints);
    end
    // A consume only happens with pending != 0, so the subtraction cannot wrap.
    w_sum = SUM_W'(r_pending) + w_add - SUM_W'(w_update);
    w_sat = (w_sum > c_pend_max);

    if (flush) begin
      w_pending_nxt  = '0;
      w_win_cnt_nxt  = '0;
      w_overflow_nxt = 1'b0;
    end else begin
      w_pending_nxt  = w_sat ? c_pend_max[PEND_W-1:0] : w_sum[PEND_W-1:0];
      w_win_cnt_nxt  = inUpdatePositionStateMain ? (r_win_cnt + 3'(w_update)) : 3'd0;
      w_overflow_nxt = r_overflow | w_sat;
    end

    if (w_pending_nxt == '0) begin
      w_state_nxt = ST_IDLE;
    end else if (inUpdatePositionStateMain && (w_win_cnt_nxt < c_win_max)) begin
      w_state_nxt = ST_SEND;
    end else begin
      w_state_nxt = ST_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_win_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_win_cnt  <= w_win_cnt_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign updateScore = w_update;
  assign pending     = r_pending;
  assign overflow    = r_overflow;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_score_event_tx.sv
`default_nettype none
// ============================================================================
// tb_score_event_tx : directed scenarios plus random traffic against a
//                     credit-ledger model, for MAX_PER_WINDOW of 1 and 3.
// Revision 1.0
// ============================================================================
module tb_score_event_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hit = 1'b0;
  logic [1:0] hitPoints = 2'd0;
  logic       flush = 1'b0;
  logic       win = 1'b0;

  logic [1:0] upd;
  logic [4:0] pend_a [2];
  logic [1:0] ovf;
  logic [1:0] bsy;

  int  vectors = 0;
  int  miscompares = 0;
  bit  chk_en = 1'b0;
  bit  upd_s [2];

  // Ledger model: credits owed, pulses used in the current window, loss flag.
  int  m_pend [2] = '{0, 0};
  int  m_cnt  [2] = '{0, 0};
  bit  m_ovf  [2] = '{1'b0, 1'b0};
  int  m_max  [2] = '{1, 3};

  always #5 clk = ~clk;

  score_event_tx #(.PEND_W(5), .MAX_PER_WINDOW(1)) u_dut1 (
    .clk(clk), .reset(reset), .hit(hit), .hitPoints(hitPoints), .flush(flush),
    .inUpdatePositionStateMain(win), .updateScore(upd[0]), .pending(pend_a[0]),
    .overflow(ovf[0]), .busy(bsy[0])
  );

  score_event_tx #(.PEND_W(5), .MAX_PER_WINDOW(3)) u_dut3 (
    .clk(clk), .reset(reset), .hit(hit), .hitPoints(hitPoints), .flush(flush),
    .inUpdatePositionStateMain(win), .updateScore(upd[1]), .pending(pend_a[1]),
    .overflow(ovf[1]), .busy(bsy[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_upd(input int k);
    return !reset && (m_pend[k] != 0) && win && !flush && (m_cnt[k] < m_max[k]);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int sum;
      bit u;
      u = m_upd(k);
      if (reset || flush) begin
        m_pend[k] = 0;
        m_cnt[k]  = 0;
        m_ovf[k]  = 1'b0;
      end else begin
        sum = m_pend[k] + (hit ? int'(hitPoints) : 0) - (u ? 1 : 0);
        if (sum > 31) begin
          m_pend[k] = 31;
          m_ovf[k]  = 1'b1;
        end else begin
          m_pend[k] = sum;
        end
        m_cnt[k] = win ? m_cnt[k] + (u ? 1 : 0) : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_upd[%0d]", k), int'(upd[k]), int'(m_upd(k)));
        chk($sformatf("model_pend[%0d]", k), int'(pend_a[k]), m_pend[k]);
        chk($sformatf("model_ovf[%0d]", k), int'(ovf[k]), int'(m_ovf[k]));
        chk($sformatf("model_busy[%0d]", k), int'(bsy[k]), int'(m_pend[k] != 0));
      end
    end
  end

  // Apply one cycle of inputs; upd_s captures the strobes seen in that cycle.
  task automatic cyc(input bit h, input int hp, input bit f, input bit w, input bit r);
    hit       = h;
    hitPoints = 2'(hp);
    flush     = f;
    win       = w;
    reset     = r;
    #2;
    upd_s[0] = upd[0];
    upd_s[1] = upd[1];
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    cyc(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    cyc(0, 0, 0, 0, 1);
    chk("reset_pending", int'(pend_a[0]), 0);
    chk("reset_overflow", int'(ovf[0]), 0);
    chk("reset_busy", int'(bsy[0]), 0);

    // Single hit, then two windows of one pulse each
    cyc(1, 2, 0, 0, 0);
    chk("single_hit_upd", int'(upd_s[0]), 0);
    chk("single_hit_pending", int'(pend_a[0]), 2);
    chk("single_hit_busy", int'(bsy[0]), 1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      n += int'(upd_s[0]);
    end
    chk("win1_pulses", n, 1);
    chk("win1_pending", int'(pend_a[0]), 1);
    cyc(0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1, 0);
      n += int'(upd_s[0]);
    end
    chk("win2_pulses", n, 1);
    chk("win2_pending", int'(pend_a[0]), 0);
    chk("win2_idle", int'(bsy[0]), 0);

    // Hit and consume in the same cycle
    cyc(0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 3, 0, 1, 0);
    chk("simul_upd", int'(upd_s[0]), 1);
    chk("simul_pending", int'(pend_a[0]), 3);
    cyc(0, 0, 1, 0, 0);

    // Saturation and flush recovery
    for (int i = 1; i <= 11; i++) begin
      cyc(1, 3, 0, 0, 0);
      if (i == 10) begin
        chk("sat_pending_30", int'(pend_a[0]), 30);
        chk("sat_ovf_before", int'(ovf[0]), 0);
      end
    end
    chk("sat_pending_31", int'(pend_a[0]), 31);
    chk("sat_ovf_after", int'(ovf[0]), 1);
    cyc(1, 3, 0, 0, 0);
    chk("sat_hold", int'(pend_a[0]), 31);
    cyc(0, 0, 1, 0, 0);
    chk("flush_pending", int'(pend_a[0]), 0);
    chk("flush_ovf", int'(ovf[0]), 0);

    // Window quota with MAX_PER_WINDOW = 3
    cyc(1, 3, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    chk("quota_pending5", int'(pend_a[1]), 5);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk($sformatf("quota_upd_c%0d", i), int'(upd_s[1]), (i < 3) ? 1 : 0);
    end
    chk("quota_pending2", int'(pend_a[1]), 2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("quota_short_upd", int'(upd_s[1]), 1);
    chk("quota_pending1", int'(pend_a[1]), 1);
    cyc(0, 0, 1, 0, 0);

    // Reset mid-window
    cyc(1, 2, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    chk("rst_pending4", int'(pend_a[0]), 4);
    cyc(0, 0, 0, 1, 1);
    chk("rst_upd_during", int'(upd_s[0]), 0);
    chk("rst_pending0", int'(pend_a[0]), 0);
    cyc(0, 0, 0, 1, 0);
    chk("rst_upd_after", int'(upd_s[0]), 0);
    cyc(1, 1, 0, 1, 0);
    chk("rst_hit_upd", int'(upd_s[0]), 0);
    cyc(0, 0, 0, 1, 0);
    chk("rst_next_upd", int'(upd_s[0]), 1);
    cyc(0, 0, 0, 0, 0);

    // Flush beats a simultaneous hit
    cyc(1, 3, 1, 1, 0);
    chk("flush_hit_upd", int'(upd_s[0]), 0);
    chk("flush_hit_pending", int'(pend_a[0]), 0);
    cyc(0, 0, 0, 1, 0);
    chk("flush_hit_idle_upd", int'(upd_s[0]), 0);
    chk("flush_hit_idle_busy", int'(bsy[0]), 0);

    // Random traffic, checked cycle by cycle against the ledger model
    for (int i = 0; i < 4000; i++) begin
      bit w;
      w = win;
      if ($urandom_range(0, 99) < 20) w = ~w;
      cyc(($urandom_range(0, 99) < 45), int'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 2), w, ($urandom_range(0, 199) < 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
